seven_seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a NUM_DIGITS common-segment 7-segment display. All digits share one BCD-to-7-segment decoder.
- Sequences one digit at a time onto the decoder input (bcd_out) and drives the matching one-hot digit enable.
- Inserts an anti-ghosting blank gap before every digit.
- Double-buffers host digit data so a frame never shows a mix of old and new digits (no tearing).
- The downstream decoder maps codes 0-9 to glyphs and any other code to all segments off; this block uses 4'hF as its blank code.

---
 rtl/seven_seg_scan_ctrl.sv | 107 ++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// seven_seg_scan_ctrl: double-buffered, blank-gapped multiplexed 7-segment scanner.
// Optional LEADING_ZERO_BLANK_EN replaces leading zero digits with the blank code at transfer.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_en
);
  localparam int CMAX = REFRESH_DIV > BLANK_CYCLES ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int DW   = 4 * NUM_DIGITS;
  typedef enum logic {BLANK, DRIVE} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic [DW-1:0]         shadow_q, shadow_d, display_q, display_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;
  logic [3:0]            bcd_q, bcd_d;
  logic                  load_ack_q, load_ack_d, frame_start_q, frame_start_d;
  logic                  xfer;
  function automatic logic [DW-1:0] fmt(input logic [DW-1:0] v);
`ifdef LEADING_ZERO_BLANK_EN
    logic lead;
    fmt  = v;
    lead = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      lead = lead && (v[4*i+:4] == 4'h0);
      if (lead) fmt[4*i+:4] = 4'hF;
    end
`else
    fmt = v;
`endif
  endfunction
  // BLANK counts 1..BLANK_CYCLES so the idle count of 0 after reset or disable adds the extra lead-in cycle
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q + 1'b1;
    pending_d     = pending_q | load;
    shadow_d      = load ? digits_in : shadow_q;
    display_d     = display_q;
    load_ack_d    = 1'b0;
    frame_start_d = 1'b0;
    xfer          = 1'b0;
    if (!enable) begin
      state_d = BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == BLANK && cnt_q == CW'(BLANK_CYCLES)) begin
      state_d       = DRIVE;
      cnt_d         = '0;
      xfer          = idx_q == '0;
      frame_start_d = xfer;
    end else if (state_q == DRIVE && cnt_q == CW'(REFRESH_DIV - 1)) begin
      state_d = BLANK;
      cnt_d   = CW'(1);
      idx_d   = idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
    end
    if (xfer && (pending_q || load)) begin
      display_d  = fmt(load ? digits_in : shadow_q);
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end
    digit_en_d = state_d == DRIVE ? NUM_DIGITS'(1) << idx_d : '0;
    bcd_d      = state_d == DRIVE ? display_d[4*idx_d+:4] : 4'hF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      cnt_q         <= '0;
      pending_q     <= 1'b0;
      shadow_q      <= '1;
      display_q     <= '1;
      digit_en_q    <= '0;
      bcd_q         <= 4'hF;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pending_q     <= pending_d;
      shadow_q      <= shadow_d;
      display_q     <= display_d;
      digit_en_q    <= digit_en_d;
      bcd_q         <= bcd_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end
  assign digit_en    = digit_en_q;
  assign bcd_out     = bcd_q;
  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb_seven_seg_scan_ctrl: directed checks of scan timing, double buffering, disable and reset.
module tb_seven_seg_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst, enable, load, load_ack, frame_start;
  logic [15:0] digits_in;
  logic [3:0]  bcd_out, digit_en;
  int          total = 0, fails = 0, fr = 0;
  logic [15:0] cur;
  seven_seg_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in), .load(load),
    .load_ack(load_ack), .frame_start(frame_start), .bcd_out(bcd_out), .digit_en(digit_en)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    obs = {digit_en, bcd_out, load_ack, frame_start};
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got en/bcd/ack/fs=%h required %h", tag, obs, exp);
    end
  endtask
  // frame position p: slot p/6, first two cycles of each slot blank, next four drive
  task automatic run_frame(input logic [15:0] disp, input logic ack, input int lp1,
                           input logic [15:0] lv1, input int lp2, input logic [15:0] lv2);
    int slot, off;
    logic [3:0] en, bcd;
    for (int p = 0; p < 24; p++) begin
      load = 1'b0;
      if (p == lp1) begin load = 1'b1; digits_in = lv1; end
      if (p == lp2) begin load = 1'b1; digits_in = lv2; end
      tick;
      slot = p / 6;
      off  = p % 6;
      en   = off >= 2 ? 4'b0001 << slot : 4'b0000;
      bcd  = off >= 2 ? disp[4*slot+:4] : 4'hF;
      chk($sformatf("frame%0d_p%0d", fr, p), {en, bcd, ack && p == 2, p == 2});
    end
    load = 1'b0;
    fr++;
  endtask
  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0; digits_in = 16'h0;
    tick; tick; tick;
    chk("reset_hold", {4'b0000, 4'hF, 1'b0, 1'b0});
    rst = 1'b0;
    run_frame(16'hFFFF, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame(16'hFFFF, 1'b0, 8, 16'h1234, -1, 16'h0);
    run_frame(16'h1234, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame(16'h1234, 1'b0, 8, 16'h1111, 14, 16'h5678);
    run_frame(16'h5678, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame(16'h5678, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame(16'h9000, 1'b1, 2, 16'h9000, -1, 16'h0);
    run_frame(16'h9000, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame(16'h9000, 1'b0, 8, 16'h0070, -1, 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
    cur = 16'hFF70;
`else
    cur = 16'h0070;
`endif
    run_frame(cur, 1'b1, -1, 16'h0, -1, 16'h0);
    run_frame(cur, 1'b0, 8, 16'h0000, -1, 16'h0);
`ifdef LEADING_ZERO_BLANK_EN
    cur = 16'hFFF0;
`else
    cur = 16'h0000;
`endif
    run_frame(cur, 1'b1, -1, 16'h0, -1, 16'h0);
    for (int i = 0; i < 15; i++) tick;
    chk("digit2_drive", {4'b0100, cur[11:8], 1'b0, 1'b0});
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("disabled_%0d", i), {4'b0000, 4'hF, 1'b0, 1'b0});
    end
    enable = 1'b1;
    run_frame(cur, 1'b0, -1, 16'h0, -1, 16'h0);
    tick; tick; tick;
    chk("pre_reset_d0", {4'b0001, cur[3:0], 1'b0, 1'b1});
    load = 1'b1; digits_in = 16'h4321;
    tick;
    load = 1'b0; rst = 1'b1;
    tick;
    chk("mid_reset", {4'b0000, 4'hF, 1'b0, 1'b0});
    rst = 1'b0;
    run_frame(16'hFFFF, 1'b0, -1, 16'h0, -1, 16'h0);
    run_frame(16'hFFFF, 1'b0, -1, 16'h0, -1, 16'h0);
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
